jtcontra_sndcmd_fifo: RTL and testbench

Parametrised main-to-sound command channel for the Konami-era cores: the successor of the single 8-bit sound latch plus IRQ pulse between main and sound CPUs. Provides CH independent FIFO channels of 2**AW words each, with per-channel full/empty/overflow status, a pending-channel encoder and a configurable sound-CPU interrupt. Sits between `jtcontra_main`'s latch write decode and the sound CPU's latch read decode, both on the 24 MHz domain.

---
 rtl/jtcontra_sndcmd_fifo.sv | 154 +++++++++++++++
 tb/tb_jtcontra_sndcmd_fifo.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_sndcmd_fifo.sv
// jtcontra_sndcmd_fifo
// Main-to-sound command channel: CH independent FIFOs of 2**AW words each.
// It reports per-channel full, empty and sticky overflow status.
// A priority encoder names the lowest pending channel.
// The sound-CPU interrupt is either level or sticky, selected by IRQ_MODE.
// Main and sound sides both run on the single 24 MHz clock domain.
module jtcontra_sndcmd_fifo #(
    parameter int CH       = 2,
    parameter int DW       = 8,
    parameter int AW       = 2,
    parameter int IRQ_MODE = 0,
    localparam int CW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          main_we,
    input  logic [CW-1:0] main_ch,
    input  logic [DW-1:0] main_din,
    output logic [CH-1:0] main_full,
    input  logic          snd_rd,
    input  logic [CW-1:0] snd_ch,
    output logic [DW-1:0] snd_dout,
    output logic [CH-1:0] snd_empty,
    output logic [CW-1:0] snd_pend,
    output logic          snd_irq,
    input  logic          irq_ack,
    output logic [CH-1:0] ovf,
    input  logic          ovf_clr
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem    [CH][DEPTH];
    logic [AW-1:0] wr_ptr [CH];
    logic [AW-1:0] rd_ptr [CH];
    logic [AW:0]   cnt    [CH];

    logic [CH-1:0] wr_hit;
    logic [CH-1:0] wr_ok;
    logic [CH-1:0] rd_ok;
    logic [CH-1:0] ovf_set;
    logic [DW-1:0] head_word;

    // Decide per channel which accesses are accepted.
    // A pop on a full channel frees a slot, so a same-cycle write to it is accepted.
    // A pop on an empty channel is never satisfied by the write arriving in the same cycle.
    always_comb begin
        wr_hit    = '0;
        wr_ok     = '0;
        rd_ok     = '0;
        ovf_set   = '0;
        head_word = '0;
        for (int i = 0; i < CH; i++) begin
            wr_hit[i]  = main_we && (main_ch == CW'(i));
            rd_ok[i]   = snd_rd && (snd_ch == CW'(i)) && (cnt[i] != '0);
            wr_ok[i]   = wr_hit[i] && ((cnt[i] != FULL_CNT) || rd_ok[i]);
            ovf_set[i] = wr_hit[i] && !wr_ok[i];
            if (rd_ok[i]) begin
                head_word = mem[i][rd_ptr[i]];
            end
        end
    end

    // Storage array; intentionally not reset because the counts define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (wr_ok[i]) begin
                mem[i][wr_ptr[i]] <= main_din;
            end
        end
    end

    // Pointers and occupancy counts; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < CH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (wr_ok[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (rd_ok[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                if (wr_ok[i] && !rd_ok[i]) begin
                    cnt[i] <= cnt[i] + (AW + 1)'(1);
                end else if (rd_ok[i] && !wr_ok[i]) begin
                    cnt[i] <= cnt[i] - (AW + 1)'(1);
                end
            end
        end
    end

    // Registered read data; it holds its value when no pop is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snd_dout <= '0;
        end else if (|rd_ok) begin
            snd_dout <= head_word;
        end
    end

    // Sticky overflow flags; a new overflow wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~{CH{ovf_clr}}) | ovf_set;
        end
    end

    // Sound-CPU interrupt.
    // In level mode it follows "any data queued" one cycle late.
    // In sticky mode an accepted write beats a same-cycle acknowledge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snd_irq <= 1'b0;
        end else if (IRQ_MODE == 1) begin
            if (|wr_ok) begin
                snd_irq <= 1'b1;
            end else if (irq_ack) begin
                snd_irq <= 1'b0;
            end
        end else begin
            snd_irq <= ~&snd_empty;
        end
    end

    // Full and empty flags decoded straight from the registered counts.
    always_comb begin
        main_full = '0;
        snd_empty = '0;
        for (int i = 0; i < CH; i++) begin
            main_full[i] = (cnt[i] == FULL_CNT);
            snd_empty[i] = (cnt[i] == '0);
        end
    end

    // Lowest-index non-empty channel; scanning downwards lets the lowest index win.
    always_comb begin
        snd_pend = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (!snd_empty[i]) begin
                snd_pend = CW'(i);
            end
        end
    end

endmodule

// File: tb/tb_jtcontra_sndcmd_fifo.sv
// Testbench for jtcontra_sndcmd_fifo.
// Instance A: CH=2, level IRQ.  Instance B: CH=3, sticky IRQ.
// A queue-based reference model tracks both instances cycle by cycle.
module tb_jtcontra_sndcmd_fifo;

    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    logic       a_we = 0, a_rd = 0, a_ack = 0, a_clr = 0;
    logic [0:0] a_wch = 0, a_rch = 0;
    logic [7:0] a_din = 0;
    logic [1:0] a_full, a_empty, a_ovf;
    logic [7:0] a_dout;
    logic [0:0] a_pend;
    logic       a_irq;

    logic       b_we = 0, b_rd = 0, b_ack = 0, b_clr = 0;
    logic [1:0] b_wch = 0, b_rch = 0;
    logic [7:0] b_din = 0;
    logic [2:0] b_full, b_empty, b_ovf;
    logic [7:0] b_dout;
    logic [1:0] b_pend;
    logic       b_irq;

    jtcontra_sndcmd_fifo #(.CH(2), .DW(8), .AW(2), .IRQ_MODE(0)) dut_a (
        .clk(clk), .rstn(rstn),
        .main_we(a_we), .main_ch(a_wch), .main_din(a_din), .main_full(a_full),
        .snd_rd(a_rd), .snd_ch(a_rch), .snd_dout(a_dout), .snd_empty(a_empty),
        .snd_pend(a_pend), .snd_irq(a_irq), .irq_ack(a_ack),
        .ovf(a_ovf), .ovf_clr(a_clr)
    );

    jtcontra_sndcmd_fifo #(.CH(3), .DW(8), .AW(2), .IRQ_MODE(1)) dut_b (
        .clk(clk), .rstn(rstn),
        .main_we(b_we), .main_ch(b_wch), .main_din(b_din), .main_full(b_full),
        .snd_rd(b_rd), .snd_ch(b_rch), .snd_dout(b_dout), .snd_empty(b_empty),
        .snd_pend(b_pend), .snd_irq(b_irq), .irq_ack(b_ack),
        .ovf(b_ovf), .ovf_clr(b_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per (instance, channel), slot k*4+ch.
    logic [7:0] mq [8][$];
    logic [7:0] m_dout [2];
    logic [3:0] m_ovf  [2];
    logic       m_irq  [2];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mq[i].delete();
        for (int k = 0; k < 2; k++) begin
            m_dout[k] = 8'h00;
            m_ovf[k]  = 4'h0;
            m_irq[k]  = 1'b0;
        end
    endtask

    task automatic model_inst(input int k, input int nch, input int mode,
                              input bit we, input int wch, input logic [7:0] din,
                              input bit rd, input int rch, input bit ack, input bit clr);
        bit         any_pre = 0;
        bit         pushed  = 0;
        logic [3:0] set     = 4'h0;
        for (int c = 0; c < nch; c++) if (mq[k*4+c].size() != 0) any_pre = 1;
        if (rd && rch < nch && mq[k*4+rch].size() != 0) m_dout[k] = mq[k*4+rch].pop_front();
        if (we && wch < nch) begin
            if (mq[k*4+wch].size() < DEPTH) begin
                mq[k*4+wch].push_back(din);
                pushed = 1;
            end else begin
                set[wch] = 1'b1;
            end
        end
        m_ovf[k] = (clr ? 4'h0 : m_ovf[k]) | set;
        if (mode == 0) m_irq[k] = any_pre;
        else if (pushed) m_irq[k] = 1'b1;
        else if (ack) m_irq[k] = 1'b0;
    endtask

    function automatic logic [3:0] m_empty(input int k, input int nch);
        logic [3:0] r = 4'h0;
        for (int c = 0; c < nch; c++) r[c] = (mq[k*4+c].size() == 0);
        return r;
    endfunction

    function automatic logic [3:0] m_full(input int k, input int nch);
        logic [3:0] r = 4'h0;
        for (int c = 0; c < nch; c++) r[c] = (mq[k*4+c].size() == DEPTH);
        return r;
    endfunction

    function automatic logic [1:0] m_pend(input int k, input int nch);
        for (int c = 0; c < nch; c++) if (mq[k*4+c].size() != 0) return 2'(c);
        return 2'd0;
    endfunction

    task automatic idle_inputs();
        a_we = 0; a_rd = 0; a_ack = 0; a_clr = 0; a_wch = 0; a_rch = 0; a_din = 0;
        b_we = 0; b_rd = 0; b_ack = 0; b_clr = 0; b_wch = 0; b_rch = 0; b_din = 0;
    endtask

    // Advance the model with the current inputs, then one clock; returns at posedge+1.
    task automatic step();
        model_inst(0, 2, 0, a_we, int'(a_wch), a_din, a_rd, int'(a_rch), a_ack, a_clr);
        model_inst(1, 3, 1, b_we, int'(b_wch), b_din, b_rd, int'(b_rch), b_ack, b_clr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({a_full, a_empty, a_ovf, a_dout, a_pend, a_irq} !== {2'b00, 2'b11, 2'b00, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_a: got full=%b empty=%b ovf=%b dout=%h pend=%0d irq=%b, expected 00 11 00 00 0 0",
                     a_full, a_empty, a_ovf, a_dout, a_pend, a_irq);
        end
        n_tests++;
        if ({b_full, b_empty, b_ovf, b_dout, b_pend, b_irq} !== {3'b000, 3'b111, 3'b000, 8'h00, 2'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL reset_b: got full=%b empty=%b ovf=%b dout=%h pend=%0d irq=%b, expected 000 111 000 00 0 0",
                     b_full, b_empty, b_ovf, b_dout, b_pend, b_irq);
        end
    endtask

    task automatic test_basic();
        a_we = 1; a_wch = 0; a_din = 8'h22;
        step();
        a_we = 0;
        n_tests++;
        if (a_empty !== 2'b10) begin n_fail++; $display("[TB] FAIL basic_empty_n1: got %b, expected 10", a_empty); end
        n_tests++;
        if (a_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_irq_n1: got %b, expected 0", a_irq); end
        step();
        n_tests++;
        if (a_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_irq_n2: got %b, expected 1", a_irq); end
        a_rd = 1; a_rch = 0;
        step();
        a_rd = 0;
        n_tests++;
        if (a_dout !== 8'h22) begin n_fail++; $display("[TB] FAIL basic_dout: got %h, expected 22", a_dout); end
        n_tests++;
        if (a_empty !== 2'b11) begin n_fail++; $display("[TB] FAIL basic_empty_pop: got %b, expected 11", a_empty); end
        step();
        n_tests++;
        if (a_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_irq_low: got %b, expected 0", a_irq); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) begin
            a_we = 1; a_wch = 1; a_din = 8'(i);
            step();
        end
        n_tests++;
        if (a_full !== 2'b10) begin n_fail++; $display("[TB] FAIL ovf_full4: got %b, expected 10", a_full); end
        n_tests++;
        if (a_ovf !== 2'b00) begin n_fail++; $display("[TB] FAIL ovf_before: got %b, expected 00", a_ovf); end
        a_din = 8'h05;
        step();
        n_tests++;
        if (a_ovf !== 2'b10) begin n_fail++; $display("[TB] FAIL ovf_set: got %b, expected 10", a_ovf); end
        a_din = 8'h06; a_clr = 1;
        step();
        a_we = 0; a_clr = 0;
        n_tests++;
        if (a_ovf !== 2'b10) begin n_fail++; $display("[TB] FAIL ovf_clr_vs_set: got %b, expected 10", a_ovf); end
        for (int i = 1; i <= 4; i++) begin
            a_rd = 1; a_rch = 1;
            step();
            n_tests++;
            if (a_dout !== 8'(i)) begin n_fail++; $display("[TB] FAIL ovf_pop%0d: got %h, expected %h", i, a_dout, 8'(i)); end
        end
        a_rd = 0;
        n_tests++;
        if (a_empty !== 2'b11) begin n_fail++; $display("[TB] FAIL ovf_drained: got %b, expected 11", a_empty); end
        a_clr = 1;
        step();
        a_clr = 0;
        n_tests++;
        if (a_ovf !== 2'b00) begin n_fail++; $display("[TB] FAIL ovf_clr: got %b, expected 00", a_ovf); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [$];
        logic [7:0] popped;
        for (int i = 0; i < 4; i++) begin
            a_we = 1; a_wch = 0; a_din = 8'h10 + 8'(i);
            exp_q.push_back(a_din);
            step();
        end
        for (int j = 0; j < 10; j++) begin
            a_we = 1; a_wch = 0; a_din = 8'hA0 + 8'(j);
            a_rd = 1; a_rch = 0;
            popped = exp_q.pop_front();
            exp_q.push_back(a_din);
            step();
            n_tests++;
            if (a_dout !== popped) begin n_fail++; $display("[TB] FAIL b2b_dout%0d: got %h, expected %h", j, a_dout, popped); end
            n_tests++;
            if ({a_full, a_ovf} !== 4'b0100) begin n_fail++; $display("[TB] FAIL b2b_flags%0d: got full=%b ovf=%b, expected 01 00", j, a_full, a_ovf); end
        end
        a_we = 0;
        for (int j = 0; j < 4; j++) begin
            popped = exp_q.pop_front();
            step();
            n_tests++;
            if (a_dout !== popped) begin n_fail++; $display("[TB] FAIL b2b_drain%0d: got %h, expected %h", j, a_dout, popped); end
        end
        a_rd = 0;
    endtask

    task automatic test_write_pop_empty();
        a_we = 1; a_wch = 0; a_din = 8'h55; a_rd = 1; a_rch = 0;
        step();
        a_we = 0;
        n_tests++;
        if (a_dout !== 8'hA9) begin n_fail++; $display("[TB] FAIL wpe_hold: got %h, expected a9", a_dout); end
        n_tests++;
        if (a_empty !== 2'b10) begin n_fail++; $display("[TB] FAIL wpe_empty: got %b, expected 10", a_empty); end
        step();
        a_rd = 0;
        n_tests++;
        if (a_dout !== 8'h55) begin n_fail++; $display("[TB] FAIL wpe_pop: got %h, expected 55", a_dout); end
    endtask

    task automatic test_pend();
        b_we = 1; b_wch = 2; b_din = 8'h31;
        step();
        b_wch = 1; b_din = 8'h21;
        step();
        b_we = 0;
        n_tests++;
        if ({b_pend, b_empty} !== {2'd1, 3'b001}) begin n_fail++; $display("[TB] FAIL pend_1: got pend=%0d empty=%b, expected 1 001", b_pend, b_empty); end
        n_tests++;
        if (b_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_irq: got %b, expected 1", b_irq); end
        b_rd = 1; b_rch = 1;
        step();
        n_tests++;
        if ({b_pend, b_dout} !== {2'd2, 8'h21}) begin n_fail++; $display("[TB] FAIL pend_2: got pend=%0d dout=%h, expected 2 21", b_pend, b_dout); end
        b_rch = 2;
        step();
        b_rd = 0;
        n_tests++;
        if ({b_pend, b_empty, b_dout} !== {2'd0, 3'b111, 8'h31}) begin n_fail++; $display("[TB] FAIL pend_0: got pend=%0d empty=%b dout=%h, expected 0 111 31", b_pend, b_empty, b_dout); end
        b_ack = 1;
        step();
        b_ack = 0;
        b_we = 1; b_wch = 3; b_din = 8'h77; b_rd = 1; b_rch = 3;
        step();
        b_we = 0; b_rd = 0;
        n_tests++;
        if ({b_full, b_empty, b_ovf, b_irq, b_dout} !== {3'b000, 3'b111, 3'b000, 1'b0, 8'h31}) begin
            n_fail++;
            $display("[TB] FAIL bad_ch: got full=%b empty=%b ovf=%b irq=%b dout=%h, expected 000 111 000 0 31", b_full, b_empty, b_ovf, b_irq, b_dout);
        end
    endtask

    task automatic test_irq_sticky();
        b_we = 1; b_wch = 0; b_din = 8'h41;
        step();
        n_tests++;
        if (b_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_set: got %b, expected 1", b_irq); end
        b_din = 8'h42; b_ack = 1;
        step();
        b_we = 0;
        n_tests++;
        if (b_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_set_vs_ack: got %b, expected 1", b_irq); end
        step();
        b_ack = 0;
        n_tests++;
        if ({b_irq, b_empty} !== {1'b0, 3'b110}) begin n_fail++; $display("[TB] FAIL irq_ack: got irq=%b empty=%b, expected 0 110", b_irq, b_empty); end
        a_we = 1; a_wch = 1; a_din = 8'h60; b_we = 1; b_wch = 1; b_din = 8'h50;
        step();
        step();
        #2;
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({a_full, a_empty, a_ovf, a_dout, a_pend, a_irq} !== {2'b00, 2'b11, 2'b00, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL midrst_a: got full=%b empty=%b ovf=%b dout=%h pend=%0d irq=%b", a_full, a_empty, a_ovf, a_dout, a_pend, a_irq);
        end
        n_tests++;
        if ({b_full, b_empty, b_ovf, b_dout, b_pend, b_irq} !== {3'b000, 3'b111, 3'b000, 8'h00, 2'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL midrst_b: got full=%b empty=%b ovf=%b dout=%h pend=%0d irq=%b", b_full, b_empty, b_ovf, b_dout, b_pend, b_irq);
        end
        do_reset();
        step();
        n_tests++;
        if ({a_empty, b_empty, a_irq, b_irq} !== {2'b11, 3'b111, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL midrst_after: got a_empty=%b b_empty=%b a_irq=%b b_irq=%b, expected 11 111 0 0", a_empty, b_empty, a_irq, b_irq);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            a_we  = ($urandom_range(0, 99) < 55);
            a_wch = 1'($urandom_range(0, 1));
            a_din = 8'($urandom);
            a_rd  = ($urandom_range(0, 99) < 50);
            a_rch = 1'($urandom_range(0, 1));
            a_ack = ($urandom_range(0, 9) == 0);
            a_clr = ($urandom_range(0, 9) == 0);
            b_we  = ($urandom_range(0, 99) < 55);
            b_wch = 2'($urandom_range(0, 3));
            b_din = 8'($urandom);
            b_rd  = ($urandom_range(0, 99) < 45);
            b_rch = 2'($urandom_range(0, 3));
            b_ack = ($urandom_range(0, 4) == 0);
            b_clr = ($urandom_range(0, 9) == 0);
            step();
            n_tests++;
            if (a_dout !== m_dout[0]) begin n_fail++; $display("[TB] FAIL rand_a_dout @%0d: got %h, expected %h", n, a_dout, m_dout[0]); end
            n_tests++;
            if ({a_full, a_empty, a_ovf, a_pend} !== {m_full(0, 2)[1:0], m_empty(0, 2)[1:0], m_ovf[0][1:0], m_pend(0, 2)[0]}) begin
                n_fail++;
                $display("[TB] FAIL rand_a_flags @%0d: got full=%b empty=%b ovf=%b pend=%0d, expected %b %b %b %0d", n, a_full, a_empty, a_ovf, a_pend,
                         m_full(0, 2)[1:0], m_empty(0, 2)[1:0], m_ovf[0][1:0], m_pend(0, 2)[0]);
            end
            n_tests++;
            if (a_irq !== m_irq[0]) begin n_fail++; $display("[TB] FAIL rand_a_irq @%0d: got %b, expected %b", n, a_irq, m_irq[0]); end
            n_tests++;
            if (b_dout !== m_dout[1]) begin n_fail++; $display("[TB] FAIL rand_b_dout @%0d: got %h, expected %h", n, b_dout, m_dout[1]); end
            n_tests++;
            if ({b_full, b_empty, b_ovf, b_pend} !== {m_full(1, 3)[2:0], m_empty(1, 3)[2:0], m_ovf[1][2:0], m_pend(1, 3)}) begin
                n_fail++;
                $display("[TB] FAIL rand_b_flags @%0d: got full=%b empty=%b ovf=%b pend=%0d, expected %b %b %b %0d", n, b_full, b_empty, b_ovf, b_pend,
                         m_full(1, 3)[2:0], m_empty(1, 3)[2:0], m_ovf[1][2:0], m_pend(1, 3));
            end
            n_tests++;
            if (b_irq !== m_irq[1]) begin n_fail++; $display("[TB] FAIL rand_b_irq @%0d: got %b, expected %b", n, b_irq, m_irq[1]); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_write_pop_empty();
        test_pend();
        test_irq_sticky();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
